// File: rtl/ma_inverse_decoder.sv
// Recursive inverse of the 4-tap moving-average encoder: x[n] = (y[n] >> SHIFT) - x[n-1] - x[n-2] - x[n-3] mod 2^(N-SHIFT).
// Optional MA_DEC_ERRCNT_EN adds a saturating 8-bit count of words with nonzero low SHIFT bits.
module ma_inverse_decoder #(
    parameter int N     = 16,
    parameter int SHIFT = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         err_lsb,
    output logic [1:0]   fill_state
`ifdef MA_DEC_ERRCNT_EN
    ,
    output logic [7:0]   err_count
`endif
);

    localparam int M = N - SHIFT;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL1  = 2'd1;
    localparam logic [1:0] FILL2  = 2'd2;
    localparam logic [1:0] STEADY = 2'd3;

    // Modular difference; truncation to M bits provides the wrap.
    function automatic logic [M-1:0] decode_sample(
        input logic [M-1:0] s,
        input logic [M-1:0] a,
        input logic [M-1:0] b,
        input logic [M-1:0] c
    );
        decode_sample = s - a - b - c;
    endfunction

    function automatic logic [1:0] next_fill(input logic [1:0] st);
        case (st)
            IDLE:    next_fill = FILL1;
            FILL1:   next_fill = FILL2;
            default: next_fill = STEADY;
        endcase
    endfunction

    logic [M-1:0] h1, h2, h3;
    logic [1:0]   state;

    logic         accept;
    logic         lsb_bad_p0;
    logic [M-1:0] s_p0;
    logic [M-1:0] h1_eff, h2_eff, h3_eff;
    logic [M-1:0] x_p0;
    logic [1:0]   state_eff;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign fill_state = state;

    // Stage p0: a clear in the same cycle makes this word see zero history.
    assign s_p0       = data_in[N-1:SHIFT];
    assign lsb_bad_p0 = |data_in[SHIFT-1:0];
    assign h1_eff     = clear ? '0 : h1;
    assign h2_eff     = clear ? '0 : h2;
    assign h3_eff     = clear ? '0 : h3;
    assign state_eff  = clear ? IDLE : state;
    assign x_p0       = decode_sample(s_p0, h1_eff, h2_eff, h3_eff);

    // Stage p1: output register, history and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            err_lsb   <= 1'b0;
            h1        <= '0;
            h2        <= '0;
            h3        <= '0;
            state     <= IDLE;
        end else begin
            if (accept) begin
                data_out  <= {{SHIFT{1'b0}}, x_p0};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                h1    <= x_p0;
                h2    <= h1_eff;
                h3    <= h2_eff;
                state <= next_fill(state_eff);
            end else begin
                h1    <= h1_eff;
                h2    <= h2_eff;
                h3    <= h3_eff;
                state <= state_eff;
            end

            err_lsb <= (clear ? 1'b0 : err_lsb) | (accept && lsb_bad_p0);
        end
    end

`ifdef MA_DEC_ERRCNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [7:0] cnt_eff;
    assign cnt_eff = clear ? 8'd0 : err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (accept && lsb_bad_p0) begin
            err_count <= sat_inc8(cnt_eff);
        end else begin
            err_count <= cnt_eff;
        end
    end
`endif

endmodule

// File: tb/tb_ma_inverse_decoder.sv
// Self-checking bench for ma_inverse_decoder; random phase drives a forward encoder model and expects the original samples back.
module tb_ma_inverse_decoder;

    localparam int N     = 16;
    localparam int SHIFT = 5;
    localparam int M     = N - SHIFT;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] data_out;
    logic         err_lsb;
    logic [1:0]   fill_state;
`ifdef MA_DEC_ERRCNT_EN
    logic [7:0]   err_count;
`endif

    ma_inverse_decoder #(.N(N), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .err_lsb    (err_lsb),
        .fill_state (fill_state)
`ifdef MA_DEC_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp  = 0;
    int nfail = 0;

    // Reference state: output register, fill count, error flags, encoder delay line.
    logic        m_valid;
    int          m_data;
    int          m_fill;
    logic        m_err;
    int          m_cnt;
    int          eh[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int encode(input int x, input logic restart);
        int sum;
        sum = x;
        if (!restart) sum = sum + eh[0] + eh[1] + eh[2];
        return (sum * (1 << SHIFT)) % (1 << N);
    endfunction

    task automatic step(input logic rst_i, input logic clr_i, input logic iv, input logic orr,
                        input int y, input int xe, output logic acc);
        logic exp_rdy;
        reset     = rst_i;
        clear     = clr_i;
        in_valid  = iv;
        out_ready = orr;
        data_in   = y[N-1:0];
        #1;
        exp_rdy = !m_valid || orr;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = iv && exp_rdy && !rst_i;
        @(posedge clk);
        if (rst_i) begin
            m_valid = 1'b0; m_data = 0; m_fill = 0; m_err = 1'b0; m_cnt = 0;
            eh[0] = 0; eh[1] = 0; eh[2] = 0;
        end else begin
            if (acc) begin
                m_valid = 1'b1;
                m_data  = xe;
            end else if (m_valid && orr) begin
                m_valid = 1'b0;
            end
            if (clr_i) begin
                m_fill = 0; m_err = 1'b0; m_cnt = 0;
                eh[0] = 0; eh[1] = 0; eh[2] = 0;
            end
            if (acc) begin
                if (m_fill < 3) m_fill++;
                if ((y % (1 << SHIFT)) != 0) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                eh[2] = eh[1]; eh[1] = eh[0]; eh[0] = xe;
            end
        end
        #1;
        reset = 1'b0;
        clear = 1'b0;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("fill_state", 32'(fill_state), 32'(m_fill));
        check("err_lsb", 32'(err_lsb), 32'(m_err));
`ifdef MA_DEC_ERRCNT_EN
        check("err_count", 32'(err_count), 32'(m_cnt));
`endif
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, acc);
    endtask

    task automatic send(input int y, input int xe);
        logic acc;
        step(1'b0, 1'b0, 1'b1, 1'b1, y, xe, acc);
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    initial begin
        logic acc;
        int   x_pend;
        int   y;
        int   noise;
        logic clr;

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        m_valid = 1'b0; m_data = 0; m_fill = 0; m_err = 1'b0; m_cnt = 0;
        eh[0] = 0; eh[1] = 0; eh[2] = 0;
        @(posedge clk); #1;

        // Reset state and basic decode.
        do_reset();
        send(32, 1);
        send(96, 2);
        send(192, 3);
        send(320, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, acc);

        // Wrap-around: encoder of x=2047 repeated.
        do_reset();
        send(65504, 2047);
        send(65472, 2047);
        send(65440, 2047);
        send(65408, 2047);

        // Backpressure: output frozen, input held, then released in order.
        do_reset();
        send(32, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 96, 2, acc);
            check("bp_held", 32'(acc), 32'd0);
        end
        send(96, 2);
        send(192, 3);
        send(320, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, acc);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, acc);

        // LSB error is sticky; word still decodes from upper bits.
        do_reset();
        send(16'h0021, 1);
        send(64, 1);
        send(64, 0);

        // clear mid-stream together with an accept.
        do_reset();
        send(32, 1);
        send(96, 2);
        send(192, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 160, 5, acc);
        check("clear_accept", 32'(acc), 32'd1);
        // clear alone keeps pending output under backpressure.
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, acc);
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, acc);

        // Reset mid-stream discards pending output.
        do_reset();
        send(32, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 96, 2, acc);
        send(32, 1);

        // Many errored words: counter saturation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            x_pend = int'($urandom_range(0, (1 << M) - 1));
            send(encode(x_pend, 1'b0) | 1, x_pend);
        end

        // Randomized traffic against the forward encoder model.
        do_reset();
        x_pend = int'($urandom_range(0, (1 << M) - 1));
        for (int i = 0; i < 600; i++) begin
            clr   = ($urandom_range(0, 40) == 0);
            noise = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, (1 << SHIFT) - 1)) : 0;
            y     = encode(x_pend, clr) | noise;
            step(1'b0, clr, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), y, x_pend, acc);
            if (acc) x_pend = int'($urandom_range(0, (1 << M) - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
